// File: rtl/filter_pkg.sv
`default_nettype none
// ============================================================================
// filter_pkg : encodings shared by the packet parser and result_gate
// Rev 1.0
// ============================================================================
package filter_pkg;

    typedef enum logic [1:0] {
        WAIT_RESULT = 2'd0,
        FORWARD     = 2'd1,
        DROP        = 2'd2
    } gate_state_e;

    localparam logic RESULT_PASS = 1'b1;
    localparam logic RESULT_DROP = 1'b0;

endpackage
`default_nettype wire

// File: rtl/result_gate_if.sv
`default_nettype none
// ============================================================================
// result_gate_if : AXI4-Stream beat bundle (data, strobes, user, valid/ready/last)
// Rev 1.0
// ============================================================================
interface result_gate_if #(
    parameter int DATA_WIDTH  = 256,
    parameter int TUSER_WIDTH = 128
);
    logic [DATA_WIDTH-1:0]   tdata;
    logic [DATA_WIDTH/8-1:0] tstrb;
    logic [TUSER_WIDTH-1:0]  tuser;
    logic                    tvalid;
    logic                    tready;
    logic                    tlast;

    modport master (output tdata, tstrb, tuser, tvalid, tlast, input tready);
    modport slave  (input tdata, tstrb, tuser, tvalid, tlast, output tready);
endinterface
`default_nettype wire

// File: rtl/fallthrough_small_fifo.sv
`default_nettype none
// ============================================================================
// fallthrough_small_fifo : FIFO whose head word is visible on dout while !empty
// Rev 1.1
// ============================================================================
module fallthrough_small_fifo #(
    parameter int WIDTH          = 72,
    parameter int MAX_DEPTH_BITS = 3
) (
    input  wire              clk,
    input  wire              rst_n,
    input  wire  [WIDTH-1:0] din,
    input  wire              wr_en,
    input  wire              rd_en,
    output logic [WIDTH-1:0] dout,
    output logic             nearly_full,
    output logic             empty
);
    localparam int DEPTH = 1 << MAX_DEPTH_BITS;
    localparam logic [MAX_DEPTH_BITS:0] FULL_LVL   = (MAX_DEPTH_BITS+1)'(DEPTH);
    localparam logic [MAX_DEPTH_BITS:0] NEARLY_LVL = (MAX_DEPTH_BITS+1)'(DEPTH - 1);

    logic [WIDTH-1:0]          mem_q [DEPTH];
    logic [MAX_DEPTH_BITS-1:0] wr_ptr_q;
    logic [MAX_DEPTH_BITS-1:0] rd_ptr_q;
    logic [MAX_DEPTH_BITS:0]   depth_q;
    logic                      do_wr;
    logic                      do_rd;

    assign empty       = (depth_q == '0);
    assign nearly_full = (depth_q >= NEARLY_LVL);
    assign do_wr       = wr_en & (depth_q != FULL_LVL);
    assign do_rd       = rd_en & ~empty;
    assign dout        = mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    // Reset only rewinds the pointers; storage contents are don't-care once empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            depth_q  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_rd) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({do_wr, do_rd})
                2'b10:   depth_q <= depth_q + 1'b1;
                2'b01:   depth_q <= depth_q - 1'b1;
                default: depth_q <= depth_q;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: rtl/pkt_stat_counter.sv
`default_nettype none
// ============================================================================
// pkt_stat_counter : 32-bit wrapping event counter with increment enable
// Rev 1.0
// ============================================================================
module pkt_stat_counter (
    input  wire         clk,
    input  wire         rst_n,
    input  wire         inc_i,
    output logic [31:0] count_o
);
    logic [31:0] count_q;
    logic [31:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc_i) begin
            count_d = count_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
endmodule
`default_nettype wire

// File: rtl/result_gate.sv
`default_nettype none
// ============================================================================
// result_gate : buffers the packet stream and forwards or discards each packet
//               according to one decision bit popped from the parser result FIFO
// Rev 1.0
// ============================================================================
module result_gate
    import filter_pkg::*;
#(
    parameter int C_M_AXIS_DATA_WIDTH  = 256,
    parameter int C_S_AXIS_DATA_WIDTH  = 256,
    parameter int C_M_AXIS_TUSER_WIDTH = 128,
    parameter int C_S_AXIS_TUSER_WIDTH = 128,
    parameter int PKT_FIFO_DEPTH_BITS  = 10
) (
    input  wire          axi_aclk,
    input  wire          axi_aresetn,
    result_gate_if.slave  s_axis,
    result_gate_if.master m_axis,
    input  wire          result_dout,
    input  wire          result_empty,
    output logic         result_rd_en,
    output logic [31:0]  pkt_pass_count,
    output logic [31:0]  pkt_drop_count
);
    localparam int S_BUF_W = 1 + C_S_AXIS_TUSER_WIDTH + C_S_AXIS_DATA_WIDTH/8 + C_S_AXIS_DATA_WIDTH;
    localparam int M_BUF_W = 1 + C_M_AXIS_TUSER_WIDTH + C_M_AXIS_DATA_WIDTH/8 + C_M_AXIS_DATA_WIDTH;

    gate_state_e         state_q;
    logic [S_BUF_W-1:0]  buf_din;
    logic [M_BUF_W-1:0]  buf_dout;
    logic                buf_wr;
    logic                buf_rd;
    logic                buf_empty;
    logic                buf_nearly_full;
    logic                head_last;
    logic                m_valid;
    logic                fwd_pop;
    logic                drop_pop;

    assign s_axis.tready = ~buf_nearly_full & axi_aresetn;
    assign buf_din       = {s_axis.tlast, s_axis.tuser, s_axis.tstrb, s_axis.tdata};
    assign buf_wr        = s_axis.tvalid & s_axis.tready;

    fallthrough_small_fifo #(
        .WIDTH          (S_BUF_W),
        .MAX_DEPTH_BITS (PKT_FIFO_DEPTH_BITS)
    ) u_pkt_fifo (
        .clk         (axi_aclk),
        .rst_n       (axi_aresetn),
        .din         (buf_din),
        .wr_en       (buf_wr),
        .rd_en       (buf_rd),
        .dout        (buf_dout),
        .nearly_full (buf_nearly_full),
        .empty       (buf_empty)
    );

    assign {m_axis.tlast, m_axis.tuser, m_axis.tstrb, m_axis.tdata} = buf_dout;
    assign head_last = buf_dout[M_BUF_W-1];

    // A decision is only consumed once its packet has at least one beat buffered.
    assign result_rd_en  = (state_q == WAIT_RESULT) & ~result_empty & ~buf_empty;
    assign m_valid       = (state_q == FORWARD) & ~buf_empty;
    assign m_axis.tvalid = m_valid;
    assign fwd_pop       = m_valid & m_axis.tready;
    assign drop_pop      = (state_q == DROP) & ~buf_empty;
    assign buf_rd        = fwd_pop | drop_pop;

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            state_q <= WAIT_RESULT;
        end else begin
            case (state_q)
                WAIT_RESULT: begin
                    if (result_rd_en) begin
                        state_q <= (result_dout == RESULT_PASS) ? FORWARD : DROP;
                    end
                end
                FORWARD: begin
                    if (fwd_pop && head_last) begin
                        state_q <= WAIT_RESULT;
                    end
                end
                DROP: begin
                    if (drop_pop && head_last) begin
                        state_q <= WAIT_RESULT;
                    end
                end
                default: state_q <= WAIT_RESULT;
            endcase
        end
    end

    pkt_stat_counter u_pass_cnt (
        .clk     (axi_aclk),
        .rst_n   (axi_aresetn),
        .inc_i   (fwd_pop & head_last),
        .count_o (pkt_pass_count)
    );

    pkt_stat_counter u_drop_cnt (
        .clk     (axi_aclk),
        .rst_n   (axi_aresetn),
        .inc_i   (drop_pop & head_last),
        .count_o (pkt_drop_count)
    );
endmodule
`default_nettype wire
